// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-outstanding instruction fetch sequencer with control-flow redirect
// Owns the PC, issues one req/gnt/rvalid fetch at a time and presents (pc, insn) to decode.
module fetch_sequencer #(
  parameter int unsigned       DWIDTH   = 32,
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [AWIDTH-1:0] pc_out_q, pc_out_d;
  logic [DWIDTH-1:0] insn_q, insn_d;
  logic [AWIDTH-1:0] target;

  assign target = redirect_pc_i & ~AWIDTH'(3);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    pc_out_d = pc_out_q;
    insn_d   = insn_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          state_d = S_WAIT;
        end
        // A redirect racing the grant leaves a stale response in flight; mark it for discard.
        if (redirect_i) begin
          pc_d   = target;
          drop_d = imem_gnt_i;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
          if (!drop_q && !redirect_i) begin
            state_d  = S_HOLD;
            pc_out_d = pc_q;
            insn_d   = imem_rdata_i;
          end
        end else if (redirect_i) begin
          drop_d = 1'b1;
        end
        if (redirect_i) begin
          pc_d = target;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (out_ready_i) begin
          pc_d    = pc_q + AWIDTH'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= BASEADDR;
      drop_q   <= 1'b0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      pc_out_q <= BASEADDR;
      insn_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
      insn_q   <= insn_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign out_valid_o = valid_q;
  assign pc_o        = pc_out_q;
  assign insn_o      = insn_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized bench for fetch_sequencer
// Memory and decode are modelled at transaction level; delivered (pc, insn) pairs are scoreboarded.
module tb_fetch_sequencer;

  localparam logic [31:0] BASE = 32'h01000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [31:0] insn_out;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .pc_o          (pc_out),
    .insn_o        (insn_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // memory knobs and state
  bit          gnt_hold, rv_hold, rv_force, rand_mode;
  logic [31:0] force_data;
  bit          mem_busy, mem_stale;
  logic [31:0] mem_addr;
  int          mem_wait;

  // reference model
  logic [31:0] exp_next;
  int          hs_count;
  int          cyc, last_gnt_cyc;
  bit          prev_ok, prev_valid, prev_ready, prev_redirect, prev_req, prev_gnt;
  logic [31:0] prev_pc, prev_insn, prev_addr, prev_target;

  // Called at a negedge: drive memory, check/update the model, advance one clock.
  task automatic cycle();
    bit          deliver, grant;
    logic [31:0] gaddr;
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = $urandom;
    if (imem_req === 1'b1 && !mem_busy && !gnt_hold)
      gnt = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    else if (rand_mode)
      gnt = ($urandom_range(0, 5) == 0);
    deliver = mem_busy && mem_wait == 0 && !rv_hold;
    if (deliver) begin
      rvalid = 1'b1;
      rdata  = mem_word(mem_addr);
    end else if (rv_force || (rand_mode && !mem_busy && $urandom_range(0, 7) == 0)) begin
      rvalid = 1'b1;
      rdata  = force_data ^ $urandom;
    end

    if (!rst) begin
      exp_next = BASE;
      if (mem_busy) mem_stale = 1'b1;
    end else begin
      chk("single_outstanding", 32'(imem_req && mem_busy && !mem_stale), 32'd0);
      if (prev_ok && prev_valid && !prev_ready && !prev_redirect) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_pc", pc_out, prev_pc);
        chk("hold_insn", insn_out, prev_insn);
      end
      if (prev_ok && prev_valid && (prev_ready || prev_redirect))
        chk("valid_drop", 32'(out_valid), 32'd0);
      if (prev_ok && prev_req && !prev_gnt) begin
        chk("req_hold", 32'(imem_req), 32'd1);
        chk("req_addr", imem_addr, prev_redirect ? (prev_target & ~32'd3) : prev_addr);
      end
      if (imem_req && gnt && !redirect)
        chk("fetch_addr", imem_addr, exp_next);
      if (out_valid && out_ready) begin
        chk("deliver_pc", pc_out, exp_next);
        chk("deliver_insn", insn_out, mem_word(pc_out));
        hs_count++;
        exp_next = pc_out + 32'd4;
      end
      if (redirect) exp_next = redirect_pc & ~32'd3;
    end

    prev_ok       = rst;
    prev_valid    = out_valid;
    prev_ready    = out_ready;
    prev_redirect = redirect;
    prev_target   = redirect_pc;
    prev_req      = imem_req;
    prev_gnt      = gnt;
    prev_addr     = imem_addr;
    prev_pc       = pc_out;
    prev_insn     = insn_out;
    grant = (imem_req === 1'b1) && gnt;
    gaddr = imem_addr;
    if (grant) last_gnt_cyc = cyc;

    @(posedge clk);
    if (deliver) begin
      mem_busy  = 1'b0;
      mem_stale = 1'b0;
    end else if (mem_busy && mem_wait > 0) begin
      mem_wait--;
    end
    if (grant && rst) begin
      mem_busy  = 1'b1;
      mem_stale = 1'b0;
      mem_addr  = gaddr;
      mem_wait  = rand_mode ? int'($urandom_range(0, 3)) : 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && out_valid !== 1'b1; i++) cycle();
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 50 && imem_req !== 1'b1; i++) cycle();
    chk(tag, 32'(imem_req), 32'd1);
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b0;
    redirect = 1'b0;
    for (int i = 0; i < n; i++) begin
      cycle();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, BASE);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_pc", pc_out, BASE);
      chk("rst_insn", insn_out, 32'd0);
    end
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p, w, a;
    int          h;
    rst = 1'b0; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    gnt_hold = 0; rv_hold = 0; rv_force = 0; rand_mode = 0;
    force_data = 32'hDEADBEEF;
    mem_busy = 0; mem_stale = 0; mem_wait = 0; mem_addr = '0;
    exp_next = BASE; hs_count = 0; cyc = 0; last_gnt_cyc = 0; prev_ok = 0;
    @(negedge clk);

    // boot: three sequential fetches at minimum latency
    do_reset(3);
    cycle();
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", imem_addr, BASE);
    for (int k = 0; k < 3; k++) begin
      wait_valid("boot_valid");
      chk("boot_pc", pc_out, BASE + 32'(4 * k));
      chk("boot_latency", cyc - last_gnt_cyc, 32'd2);
      cycle();
    end

    // decode backpressure
    out_ready = 1'b0;
    wait_valid("bp_valid");
    p = pc_out;
    w = insn_out;
    chk("bp_pc", p, BASE + 32'd12);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_pc_hold", pc_out, p);
      chk("bp_insn_hold", insn_out, w);
      chk("bp_no_req", 32'(imem_req), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next_req", 32'(imem_req), 32'd1);
    chk("bp_next_addr", imem_addr, p + 32'd4);

    // grant stall with spurious rvalid
    a = imem_addr;
    gnt_hold = 1; rv_force = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, a);
      chk("stall_no_valid", 32'(out_valid), 32'd0);
    end
    gnt_hold = 0; rv_force = 0;
    wait_valid("stall_valid");
    chk("stall_pc", pc_out, a);
    chk("stall_insn", insn_out, mem_word(a));

    // redirect in HOLD together with ready
    h = hs_count;
    redirect = 1'b1; redirect_pc = 32'h01000202;
    cycle();
    redirect = 1'b0;
    chk("hr_consumed_once", hs_count, h + 1);
    chk("hr_valid_drop", 32'(out_valid), 32'd0);
    wait_req("hr_req");
    chk("hr_addr", imem_addr, 32'h01000200);
    wait_valid("hr_valid");
    chk("hr_pc", pc_out, 32'h01000200);

    // redirect while a fetch is outstanding
    do_reset(2);
    cycle();
    chk("boot2_addr", imem_addr, BASE);
    for (int k = 0; k < 2; k++) begin
      wait_valid("rw_pre_valid");
      cycle();
    end
    rv_hold = 1;
    wait_req("rw_fetch_req");
    chk("rw_fetch_addr", imem_addr, BASE + 32'd8);
    cycle();
    chk("rw_waiting", 32'(imem_req), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h01000103;
    cycle();
    redirect = 1'b0; rv_hold = 0;
    cycle();
    chk("rw_dropped", 32'(out_valid), 32'd0);
    chk("rw_req", 32'(imem_req), 32'd1);
    chk("rw_addr", imem_addr, 32'h01000100);
    wait_valid("rw_valid");
    chk("rw_pc", pc_out, 32'h01000100);
    chk("rw_insn", insn_out, mem_word(32'h01000100));

    // reset while waiting; the late response lands in IDLE
    rv_hold = 1;
    cycle();
    wait_req("rm_req");
    cycle();
    do_reset(2);
    rv_hold = 0;
    cycle();
    chk("rm_req_after", 32'(imem_req), 32'd1);
    chk("rm_addr_after", imem_addr, BASE);
    wait_valid("rm_valid");
    chk("rm_pc", pc_out, BASE);
    chk("rm_insn", insn_out, mem_word(BASE));

    // PC wrap at the top of the address space
    gnt_hold = 1;
    cycle();
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    cycle();
    redirect = 1'b0;
    chk("wrap_req", 32'(imem_req), 32'd1);
    chk("wrap_target", imem_addr, 32'hFFFFFFFC);
    gnt_hold = 0;
    wait_valid("wrap_valid");
    chk("wrap_pc", pc_out, 32'hFFFFFFFC);
    cycle();
    chk("wrap_next_req", 32'(imem_req), 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h00000000);

    // randomized traffic against the scoreboard
    rand_mode = 1;
    h = hs_count;
    for (int i = 0; i < 3000; i++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15) : $urandom;
      cycle();
    end
    redirect = 1'b0;
    chk("rand_progress", 32'(hs_count > h + 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
